fir_cfg_master: RTL and testbench



---
 rtl/fir_cfg_pkg.sv | 15 +
 rtl/axil_wr_beat.sv | 48 ++++
 rtl/fir_cfg_master.sv | 166 ++++++++++++++++
 tb/tb_fir_cfg_master.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/fir_cfg_pkg.sv
// fir_cfg_pkg: fir register map, ctrl bit positions and fir_cfg_master sequencer states
package fir_cfg_pkg;
  localparam int ADDR_CTRL = 'h00;
  localparam int ADDR_LEN  = 'h10;
  localparam int ADDR_TAP0 = 'h20;
  localparam int AP_START  = 0;
  localparam int AP_DONE   = 1;
  localparam int AP_IDLE   = 2;
  typedef enum logic [3:0] {
    S_IDLE, S_WR_LEN, S_WR_TAP, S_RB, S_WR_CTRL, S_POLL_GAP, S_RD, S_DONE, S_ERR
  } state_t;
  function automatic int tap_addr(input int i);
    return ADDR_TAP0 + 4 * i;
  endfunction
endpackage

// File: rtl/axil_wr_beat.sv
// axil_wr_beat: one AXI-Lite write beat on aw/w; done pulses in the cycle the last channel is accepted
module axil_wr_beat #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   start,
  input  logic [pADDR_WIDTH-1:0] addr,
  input  logic [pDATA_WIDTH-1:0] data,
  output logic                   done,
  output logic                   awvalid,
  output logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   awready,
  output logic                   wvalid,
  output logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   wready
);
  logic awvalid_q, awvalid_d, wvalid_q, wvalid_d, aw_hold, w_hold, go;
  logic [pADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [pDATA_WIDTH-1:0] wdata_q, wdata_d;
  always_comb begin
    aw_hold   = awvalid_q & ~awready;
    w_hold    = wvalid_q & ~wready;
    go        = start & ~awvalid_q & ~wvalid_q;
    done      = (awvalid_q | wvalid_q) & ~aw_hold & ~w_hold;
    awvalid_d = aw_hold | go;
    wvalid_d  = w_hold | go;
    awaddr_d  = go ? addr : awaddr_q;
    wdata_d   = go ? data : wdata_q;
  end
  always_ff @(posedge axis_clk or negedge axis_rst_n)
    if (!axis_rst_n) begin
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
    end else begin
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
    end
  assign awvalid = awvalid_q;
  assign wvalid  = wvalid_q;
  assign awaddr  = awaddr_q;
  assign wdata   = wdata_q;
endmodule

// File: rtl/fir_cfg_master.sv
// fir_cfg_master: AXI-Lite initiator writing len, taps and ap_start to fir, then polling ap_done.
// Define CFG_READBACK_EN to read back and verify every tap before ap_start.
module fir_cfg_master
  import fir_cfg_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11,
  parameter int POLL_GAP    = 8,
  parameter int POLL_MAX    = 1024
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   cfg_start,
  input  logic [31:0]            cfg_len,
  output logic [3:0]             coef_idx,
  input  logic [31:0]            coef_data,
  output logic                   busy,
  output logic                   cfg_done,
  output logic                   cfg_err,
  output logic                   awvalid,
  output logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   awready,
  output logic                   wvalid,
  output logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   wready,
  output logic                   arvalid,
  output logic [pADDR_WIDTH-1:0] araddr,
  input  logic                   arready,
  input  logic                   rvalid,
  output logic                   rready,
  input  logic [pDATA_WIDTH-1:0] rdata
);
  state_t state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [31:0] gap_q, gap_d, poll_q, poll_d;
  logic busy_q, busy_d, cfg_done_q, cfg_done_d, cfg_err_q, cfg_err_d;
  logic arvalid_q, arvalid_d, rready_q, rready_d;
  logic [pADDR_WIDTH-1:0] araddr_q, araddr_d, wr_addr;
  logic [pDATA_WIDTH-1:0] wr_data;
  logic wr_start, wr_done, rd_hs, last, unused_rdata;
  assign last     = idx_q == 4'(Tape_Num - 1);
  assign rd_hs    = rvalid & rready_q;
  assign wr_start = (state_q == S_WR_LEN) | (state_q == S_WR_TAP) | (state_q == S_WR_CTRL);
  assign wr_addr  = state_q == S_WR_LEN ? pADDR_WIDTH'(ADDR_LEN) :
                    state_q == S_WR_TAP ? pADDR_WIDTH'(tap_addr(int'(idx_q))) : pADDR_WIDTH'(ADDR_CTRL);
  assign wr_data  = state_q == S_WR_LEN ? pDATA_WIDTH'(cfg_len) :
                    state_q == S_WR_TAP ? pDATA_WIDTH'(coef_data) : pDATA_WIDTH'(1 << AP_START);
  assign unused_rdata = ^rdata;
  axil_wr_beat #(.pADDR_WIDTH(pADDR_WIDTH), .pDATA_WIDTH(pDATA_WIDTH)) u_wr (
    .axis_clk(axis_clk), .axis_rst_n(axis_rst_n), .start(wr_start), .addr(wr_addr), .data(wr_data),
    .done(wr_done), .awvalid(awvalid), .awaddr(awaddr), .awready(awready),
    .wvalid(wvalid), .wdata(wdata), .wready(wready)
  );
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    gap_d      = gap_q;
    poll_d     = poll_q;
    busy_d     = busy_q;
    cfg_done_d = 1'b0;
    cfg_err_d  = cfg_err_q;
    araddr_d   = araddr_q;
    arvalid_d  = arvalid_q & ~arready;
    rready_d   = rready_q & ~rvalid;
    case (state_q)
      S_IDLE: if (cfg_start) begin
        state_d   = S_WR_LEN;
        busy_d    = 1'b1;
        cfg_err_d = 1'b0;
        idx_d     = '0;
        poll_d    = '0;
      end
      S_WR_LEN: if (wr_done) state_d = S_WR_TAP;
      S_WR_TAP: if (wr_done) begin
        idx_d = last ? '0 : idx_q + 4'd1;
        if (last) begin
`ifdef CFG_READBACK_EN
          state_d   = S_RB;
          arvalid_d = 1'b1;
          rready_d  = 1'b1;
          araddr_d  = pADDR_WIDTH'(tap_addr(0));
`else
          state_d = S_WR_CTRL;
`endif
        end
      end
`ifdef CFG_READBACK_EN
      S_RB: if (rd_hs) begin
        if (rdata != pDATA_WIDTH'(coef_data)) begin
          state_d   = S_ERR;
          cfg_err_d = 1'b1;
          busy_d    = 1'b0;
          idx_d     = '0;
        end else if (last) begin
          state_d = S_WR_CTRL;
          idx_d   = '0;
        end else begin
          idx_d     = idx_q + 4'd1;
          arvalid_d = 1'b1;
          rready_d  = 1'b1;
          araddr_d  = pADDR_WIDTH'(tap_addr(int'(idx_q) + 1));
        end
      end
`endif
      S_WR_CTRL: if (wr_done) begin
        state_d = S_POLL_GAP;
        gap_d   = '0;
      end
      S_POLL_GAP: begin
        gap_d = gap_q + 32'd1;
        if (gap_q == 32'(POLL_GAP - 1)) begin
          state_d   = S_RD;
          arvalid_d = 1'b1;
          rready_d  = 1'b1;
          araddr_d  = pADDR_WIDTH'(ADDR_CTRL);
        end
      end
      S_RD: if (rd_hs) begin
        if (rdata[AP_DONE]) begin
          state_d    = S_DONE;
          cfg_done_d = 1'b1;
          busy_d     = 1'b0;
        end else begin
          poll_d    = poll_q + 32'd1;
          state_d   = poll_q + 32'd1 == 32'(POLL_MAX) ? S_ERR : S_POLL_GAP;
          cfg_err_d = poll_q + 32'd1 == 32'(POLL_MAX);
          busy_d    = poll_q + 32'd1 != 32'(POLL_MAX);
          gap_d     = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge axis_clk or negedge axis_rst_n)
    if (!axis_rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      gap_q      <= '0;
      poll_q     <= '0;
      busy_q     <= 1'b0;
      cfg_done_q <= 1'b0;
      cfg_err_q  <= 1'b0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      araddr_q   <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      gap_q      <= gap_d;
      poll_q     <= poll_d;
      busy_q     <= busy_d;
      cfg_done_q <= cfg_done_d;
      cfg_err_q  <= cfg_err_d;
      arvalid_q  <= arvalid_d;
      rready_q   <= rready_d;
      araddr_q   <= araddr_d;
    end
  assign coef_idx = idx_q;
  assign busy     = busy_q;
  assign cfg_done = cfg_done_q;
  assign cfg_err  = cfg_err_q;
  assign arvalid  = arvalid_q;
  assign rready   = rready_q;
  assign araddr   = araddr_q;
endmodule

// File: tb/tb_fir_cfg_master.sv
// tb_fir_cfg_master: directed + randomized sequences against an AXI-Lite slave model and an expected write list
module tb_fir_cfg_master;
  localparam int AW = 12, DW = 32, TAPS = 11, PG = 3, PM = 4;
  logic axis_clk = 0, axis_rst_n = 0, cfg_start = 0;
  logic [31:0] cfg_len = 0, coef_data;
  logic [3:0] coef_idx;
  logic busy, cfg_done, cfg_err, awvalid, wvalid, arvalid, rready;
  logic awready = 0, wready = 0, arready = 0, rvalid = 0;
  logic [AW-1:0] awaddr, araddr;
  logic [DW-1:0] wdata, rdata = 0;
  logic [31:0] coefs [16];
  int ncmp = 0, nerr = 0, cyc = 0;
  int zw, done_after, nreads, ndone, done_cyc, bad_ar, aw_wait, w_wait, ar_wait, rd_wait;
  bit ar_got, ar_seen;
  logic [31:0] resp;
  logic [AW-1:0] aw_log [$];
  logic [DW-1:0] w_log [$];
  int ar_rise [$], r_hs [$];
  int spec_coefs [TAPS] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};

  fir_cfg_master #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .Tape_Num(TAPS), .POLL_GAP(PG), .POLL_MAX(PM)) dut (
    .axis_clk(axis_clk), .axis_rst_n(axis_rst_n), .cfg_start(cfg_start), .cfg_len(cfg_len),
    .coef_idx(coef_idx), .coef_data(coef_data), .busy(busy), .cfg_done(cfg_done), .cfg_err(cfg_err),
    .awvalid(awvalid), .awaddr(awaddr), .awready(awready), .wvalid(wvalid), .wdata(wdata), .wready(wready),
    .arvalid(arvalid), .araddr(araddr), .arready(arready), .rvalid(rvalid), .rready(rready), .rdata(rdata)
  );

  always #5 axis_clk = ~axis_clk;
  always @(posedge axis_clk) cyc <= cyc + 1;
  assign coef_data = coefs[coef_idx];

  function automatic int rnd();
    return zw != 0 ? 0 : int'($urandom_range(0, 5));
  endfunction

  // slave: readies/rvalid decided mid-cycle; a logged handshake completes at the following posedge
  initial forever begin
    @(negedge axis_clk);
    if (!axis_rst_n) begin
      awready = 0; wready = 0; arready = 0; rvalid = 0; ar_got = 0; ar_seen = 0;
      aw_wait = rnd(); w_wait = rnd(); ar_wait = rnd();
    end else begin
      if (!awvalid) begin awready = 0; aw_wait = rnd(); end
      else if (aw_wait == 0) begin awready = 1; aw_log.push_back(awaddr); end
      else begin awready = 0; aw_wait--; end
      if (!wvalid) begin wready = 0; w_wait = rnd(); end
      else if (w_wait == 0) begin wready = 1; w_log.push_back(wdata); end
      else begin wready = 0; w_wait--; end
      if (cfg_done) begin ndone++; done_cyc = cyc; end
      arready = 0; rvalid = 0;
      if (arvalid && !ar_got) begin
        if (!ar_seen) begin ar_seen = 1; ar_rise.push_back(cyc); end
        if (ar_wait == 0) begin
          arready = 1; ar_got = 1; nreads++;
          if (araddr !== '0) bad_ar++;
          rd_wait = zw != 0 ? 0 : int'($urandom_range(0, 3));
          resp = ($urandom & 32'hFFFF_FFFD) | ((done_after != 0 && nreads >= done_after) ? 32'h2 : 32'h0);
        end else ar_wait--;
      end
      if (ar_got) begin
        if (rd_wait == 0) begin
          rvalid = 1; rdata = resp;
          if (rready) begin ar_got = 0; ar_seen = 0; ar_wait = rnd(); r_hs.push_back(cyc); end
        end else rd_wait--;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run(input logic [31:0] len, input int da, input int z, input bit poke);
    bit ok = da != 0 && da <= PM;
    bit fin = 0;
    int t0;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    zw = z; done_after = da; nreads = 0; ndone = 0; bad_ar = 0; done_cyc = 0;
    aw_log.delete(); w_log.delete(); ar_rise.delete(); r_hs.delete();
    @(negedge axis_clk); cfg_len = len; cfg_start = 1; t0 = cyc;
    @(negedge axis_clk); cfg_start = 0;
    check("busy_rise", busy, 1);
    check("err_clear", cfg_err, 0);
    if (poke) begin
      repeat (8) @(negedge axis_clk);
      cfg_start = 1;
      @(negedge axis_clk); cfg_start = 0;
    end
    for (int i = 0; i < 3000 && !fin; i++) begin
      @(negedge axis_clk);
      fin = !busy;
    end
    check("busy_timeout", fin, 1);
    repeat (3) @(negedge axis_clk);
    check("n_aw", aw_log.size(), TAPS + 2);
    check("n_w", w_log.size(), TAPS + 2);
    for (int i = 0; i < TAPS + 2 && i < aw_log.size() && i < w_log.size(); i++) begin
      ea = i == 0 ? AW'('h10) : i <= TAPS ? AW'('h20 + 4 * (i - 1)) : AW'(0);
      ed = i == 0 ? len : i <= TAPS ? coefs[i-1] : DW'(1);
      check($sformatf("beat%0d", i), {aw_log[i], w_log[i]}, {ea, ed});
    end
    check("n_reads", nreads, ok ? da : PM);
    check("n_done", ndone, ok ? 1 : 0);
    check("err_end", cfg_err, !ok);
    check("busy_end", busy, 0);
    check("rd_addr", bad_ar, 0);
    for (int k = 1; k < r_hs.size() && k < ar_rise.size(); k++)
      check("poll_gap", ar_rise[k] - r_hs[k-1], PG + 1);
    if (z != 0 && ok && da == 1)
      check("latency", (done_cyc - t0) inside {[2 * 13 + PG + 1 : 2 * 13 + PG + 4]}, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    bit hit = 0;
    for (int i = 0; i < 16; i++) coefs[i] = i < TAPS ? 32'(spec_coefs[i]) : 32'h0;
    zw = 1;
    repeat (3) @(negedge axis_clk);
    check("rst_ctl", {busy, cfg_done, cfg_err, awvalid, wvalid, arvalid, rready}, 0);
    check("rst_bus", {awaddr, wdata, araddr, coef_idx}, 0);
    axis_rst_n = 1;
    run(600, 1, 1, 0);
    run(600, 1, 0, 0);
    run(32'($urandom), 3, 0, 0);
    run(32'($urandom), 0, 0, 0);
    run(32'($urandom), 2, 1, 0);
    // abort mid-taps with an asynchronous reset, then restart cleanly
    @(negedge axis_clk); cfg_len = 77; cfg_start = 1;
    @(negedge axis_clk); cfg_start = 0;
    for (int i = 0; i < 500 && !hit; i++) begin
      @(negedge axis_clk);
      hit = coef_idx == 4'd5 && awvalid;
    end
    check("reach_tap5", hit, 1);
    #2 axis_rst_n = 0;
    #1 check("rst_async", {awvalid, wvalid, arvalid, rready, busy, cfg_done}, 0);
    @(negedge axis_clk); axis_rst_n = 1;
    run(32'($urandom), 1, 0, 0);
    run(32'($urandom), 2, 0, 1);
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < TAPS; i++) coefs[i] = $urandom;
      run(32'($urandom), int'($urandom_range(0, PM)), 0, r[0]);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
